// File: rtl/mysystem_addr_scanner.sv
// Raster address sequencer: software programs COLS/ROWS over Avalon-MM and issues a start.
// One (col,row) address is emitted per accepted valid/ready beat, in raster order.
module mysystem_addr_scanner #(
    parameter int COL_W = 16,
    parameter int ROW_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [COL_W-1:0] col_addr,
    output logic [ROW_W-1:0] row_addr,
    output logic             addr_valid,
    input  logic             addr_ready,
    output logic             line_last,
    output logic             frame_last,
    output logic             irq
);

    typedef enum logic {ST_IDLE, ST_SCAN} state_t;

    state_t           r_state, w_state_nxt;
    logic [COL_W-1:0] r_cols, r_col, w_col_nxt, w_col_max;
    logic [ROW_W-1:0] r_rows, r_row, w_row_nxt, w_row_max;
    logic             r_done, r_err, r_irq_en;
    logic [31:0]      r_frame_cnt;

    logic w_wr, w_wr_ctrl, w_wr_stat, w_wr_cols, w_wr_rows;
    logic w_start, w_abort, w_busy, w_line_last, w_frame_last;
    logic w_done_set, w_err_set, w_cnt_inc;

    assign w_wr      = chipselect & ~write_n;
    assign w_wr_ctrl = w_wr && (address == 3'd0);
    assign w_wr_stat = w_wr && (address == 3'd1);
    assign w_wr_cols = w_wr && (address == 3'd2);
    assign w_wr_rows = w_wr && (address == 3'd3);
    assign w_start   = w_wr_ctrl & writedata[0];
    assign w_abort   = w_wr_ctrl & writedata[1];
    assign w_busy    = (r_state == ST_SCAN);

    // COLS/ROWS are non-zero whenever SCAN is entered, so the decrement never wraps in use
    assign w_col_max    = r_cols - COL_W'(1);
    assign w_row_max    = r_rows - ROW_W'(1);
    assign w_line_last  = w_busy && (r_col == w_col_max);
    assign w_frame_last = w_line_last && (r_row == w_row_max);

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_done_set  = 1'b0;
        w_err_set   = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start && !w_abort) begin
                    if ((r_cols != '0) && (r_rows != '0)) begin
                        w_state_nxt = ST_SCAN;
                        w_col_nxt   = '0;
                        w_row_nxt   = '0;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                // abort beats a coincident final transfer: no done, no frame count
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                end else if (addr_ready) begin
                    if (w_frame_last) begin
                        w_state_nxt = ST_IDLE;
                        w_col_nxt   = '0;
                        w_row_nxt   = '0;
                        w_done_set  = 1'b1;
                        w_cnt_inc   = 1'b1;
                    end else if (w_line_last) begin
                        w_col_nxt = '0;
                        w_row_nxt = r_row + ROW_W'(1);
                    end else begin
                        w_col_nxt = r_col + COL_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_cols      <= '0;
            r_rows      <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_irq_en    <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            // hardware set has priority over a W1C in the same cycle
            if (w_done_set)
                r_done <= 1'b1;
            else if (w_wr_stat && writedata[1])
                r_done <= 1'b0;
            if (w_err_set)
                r_err <= 1'b1;
            else if (w_wr_stat && writedata[2])
                r_err <= 1'b0;
            if (w_cnt_inc)
                r_frame_cnt <= r_frame_cnt + 32'd1;
            if (w_wr_ctrl)
                r_irq_en <= writedata[2];
            if (w_wr_cols && !w_busy)
                r_cols <= writedata[COL_W-1:0];
            if (w_wr_rows && !w_busy)
                r_rows <= writedata[ROW_W-1:0];
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            3'd0:    readdata = {29'd0, r_irq_en, 2'b00};
            3'd1:    readdata = {29'd0, r_err, r_done, w_busy};
            3'd2:    readdata = 32'(r_cols);
            3'd3:    readdata = 32'(r_rows);
            3'd4:    readdata = r_frame_cnt;
            default: readdata = 32'd0;
        endcase
    end

    assign col_addr   = r_col;
    assign row_addr   = r_row;
    assign addr_valid = w_busy;
    assign line_last  = w_line_last;
    assign frame_last = w_frame_last;
    assign irq        = r_done & r_irq_en;

endmodule

// File: tb/tb_mysystem_addr_scanner.sv
// Bench for mysystem_addr_scanner: table of frame geometries plus hand sequences for
// error, abort, irq and reset; accepted beats are checked against a queue of expected addresses.
module tb_mysystem_addr_scanner;

    localparam int COL_W = 16;
    localparam int ROW_W = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [COL_W-1:0] col_addr;
    logic [ROW_W-1:0] row_addr;
    logic             addr_valid;
    logic             addr_ready;
    logic             line_last;
    logic             frame_last;
    logic             irq;

    mysystem_addr_scanner #(.COL_W(COL_W), .ROW_W(ROW_W)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .col_addr(col_addr), .row_addr(row_addr), .addr_valid(addr_valid),
        .addr_ready(addr_ready), .line_last(line_last), .frame_last(frame_last), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] col;
        logic [31:0] row;
        logic        ll;
        logic        fl;
    } beat_t;

    typedef struct {
        int          cols;
        int          rows;
        int          mode;        // 0: ready high, 1: ready 1,0,0,1, 2: random ready
        logic [31:0] exp_status;
    } frame_vec_t;

    beat_t      exp_q[$];
    frame_vec_t vecs[4];
    int         n_checks = 0;
    int         n_fail = 0;
    int         beats = 0;
    int         valid_cycles = 0;
    logic [31:0] exp_fcnt = 0;
    logic [31:0] rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic avs_write(input logic [2:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic avs_read(input logic [2:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
        tick();
    endtask

    task automatic push_frame(input int cols, input int rows);
        beat_t b;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                b.col = 32'(c);
                b.row = 32'(r);
                b.ll  = (c == cols - 1);
                b.fl  = (c == cols - 1) && (r == rows - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // Scoreboard: every accepted beat must match the head of the expected queue
    always @(negedge clk) begin
        beat_t e;
        if (reset_n && addr_valid) valid_cycles++;
        if (reset_n && addr_valid && addr_ready) begin
            beats++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'({col_addr, row_addr}), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("beat_addr", {32'(col_addr), 32'(row_addr)}, {e.col, e.row});
                check("beat_flags", 64'({line_last, frame_last}), 64'({e.ll, e.fl}));
            end
        end
    end

    task automatic run_frame(input frame_vec_t v);
        int cyc;
        avs_write(3'd2, 32'(v.cols));
        avs_write(3'd3, 32'(v.rows));
        push_frame(v.cols, v.rows);
        beats = 0;
        valid_cycles = 0;
        addr_ready = 1'b0;
        avs_write(3'd0, 32'h1);
        cyc = 0;
        while (addr_valid && cyc < 2000) begin
            case (v.mode)
                0:       addr_ready = 1'b1;
                1:       addr_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: addr_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            cyc++;
        end
        addr_ready = 1'b0;
        check("frame_timeout", 64'(addr_valid), 64'd0);
        check("frame_beats", 64'(beats), 64'(v.cols * v.rows));
        check("frame_queue_empty", 64'(exp_q.size()), 64'd0);
        if (v.mode == 0)
            check("frame_back_to_back", 64'(valid_cycles), 64'(v.cols * v.rows));
        exp_fcnt++;
        avs_read(3'd1, rd);
        check("frame_status", 64'(rd), 64'(v.exp_status));
        avs_read(3'd4, rd);
        check("frame_cnt", 64'(rd), 64'(exp_fcnt));
        avs_write(3'd1, 32'h2);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{3, 2, 0, 32'h2};
        vecs[1] = '{3, 2, 1, 32'h2};
        vecs[2] = '{1, 1, 0, 32'h2};
        vecs[3] = '{5, 3, 2, 32'h2};

        reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'd0; addr_ready = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        check("rst_valid", 64'(addr_valid), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        for (int a = 0; a < 5; a++) begin
            avs_read(3'(a), rd);
            check("rst_reg", 64'(rd), 64'd0);
        end

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // zero-size geometry sets err and never scans
        avs_write(3'd2, 32'd0);
        avs_write(3'd3, 32'd2);
        avs_write(3'd0, 32'h1);
        valid_cycles = 0;
        tick(); tick();
        check("err_no_valid", 64'(valid_cycles), 64'd0);
        avs_read(3'd1, rd);
        check("err_status", 64'(rd), 64'h4);
        avs_write(3'd1, 32'h4);
        avs_read(3'd1, rd);
        check("err_cleared", 64'(rd), 64'h0);

        // abort after 5 beats of a 4x4 frame, then restart from (0,0)
        avs_write(3'd2, 32'd4);
        avs_write(3'd3, 32'd4);
        push_frame(4, 4);
        beats = 0;
        avs_write(3'd0, 32'h1);
        addr_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        addr_ready = 1'b0;
        avs_write(3'd0, 32'h3);
        check("abort_valid", 64'(addr_valid), 64'd0);
        check("abort_beats", 64'(beats), 64'd5);
        check("abort_pos", 64'({col_addr, row_addr}), 64'd0);
        exp_q.delete();
        avs_read(3'd1, rd);
        check("abort_status", 64'(rd), 64'h0);
        avs_read(3'd4, rd);
        check("abort_fcnt", 64'(rd), 64'(exp_fcnt));
        run_frame('{4, 4, 0, 32'h2});

        // abort coincident with the single final transfer
        avs_write(3'd2, 32'd1);
        avs_write(3'd3, 32'd1);
        push_frame(1, 1);
        beats = 0;
        avs_write(3'd0, 32'h1);
        addr_ready = 1'b1;
        avs_write(3'd0, 32'h2);
        addr_ready = 1'b0;
        check("abort_last_beats", 64'(beats), 64'd1);
        check("abort_last_valid", 64'(addr_valid), 64'd0);
        avs_read(3'd1, rd);
        check("abort_last_status", 64'(rd), 64'h0);
        avs_read(3'd4, rd);
        check("abort_last_fcnt", 64'(rd), 64'(exp_fcnt));

        // done set wins over a coincident W1C
        push_frame(1, 1);
        avs_write(3'd0, 32'h1);
        addr_ready = 1'b1;
        avs_write(3'd1, 32'h2);
        addr_ready = 1'b0;
        exp_fcnt++;
        avs_read(3'd1, rd);
        check("done_set_wins", 64'(rd), 64'h2);
        avs_write(3'd1, 32'h2);

        // irq, start-while-busy and geometry-write-while-busy
        push_frame(1, 1);
        avs_write(3'd0, 32'h5);
        check("irq_busy_valid", 64'({addr_valid, line_last, frame_last}), 64'h7);
        avs_write(3'd2, 32'd9);
        avs_read(3'd2, rd);
        check("cols_locked", 64'(rd), 64'd1);
        avs_write(3'd0, 32'h5);
        avs_read(3'd1, rd);
        check("start_in_scan", 64'(rd), 64'h1);
        avs_read(3'd0, rd);
        check("ctrl_readback", 64'(rd), 64'h4);
        check("irq_low_busy", 64'(irq), 64'd0);
        addr_ready = 1'b1;
        tick();
        addr_ready = 1'b0;
        exp_fcnt++;
        check("irq_high", 64'(irq), 64'd1);
        avs_read(3'd4, rd);
        check("irq_fcnt", 64'(rd), 64'(exp_fcnt));
        avs_write(3'd1, 32'h2);
        check("irq_cleared", 64'(irq), 64'd0);

        // reset mid-frame
        avs_write(3'd2, 32'd4);
        avs_write(3'd3, 32'd4);
        push_frame(4, 4);
        avs_write(3'd0, 32'h5);
        addr_ready = 1'b1;
        tick(); tick(); tick();
        addr_ready = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_q.delete();
        exp_fcnt = 0;
        check("rst_mid_valid", 64'(addr_valid), 64'd0);
        check("rst_mid_pos", 64'({col_addr, row_addr}), 64'd0);
        check("rst_mid_irq", 64'(irq), 64'd0);
        for (int a = 0; a < 5; a++) begin
            avs_read(3'(a), rd);
            check("rst_mid_reg", 64'(rd), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
